// File: rtl/bus_loader_pkg.sv
// bus_loader_pkg: shared FSM states, bus-direction and width constants for bus_loader
// Optional feature macro: BUS_LOADER_VERIFY_EN adds the VERIFY read-back state.
package bus_loader_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
`ifdef BUS_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_HOLD,
    S_DONE
  } state_t;
endpackage

// File: rtl/bus_loader_release_timer.sv
// bus_loader_release_timer: down-counter timing the CPU reset hold after a load
// Ports: clk, reset_n (sync, active-low), load (reload with DELAY), expire (last hold cycle)
module bus_loader_release_timer #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expire
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) r_cnt <= '0;
    else if (load) r_cnt <= 8'(DELAY);
    else if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
  end
  assign expire = (r_cnt == 8'd1);
endmodule

// File: rtl/bus_loader.sv
// bus_loader: streams bytes into RAM over the CPU bus while holding the CPU in reset
// Inputs : clk, reset_n (sync, active-low), start, base_addr, length, in_data/in_valid, data_in
// Outputs: in_ready, addr, data_out, data_oe, RW, cpu_reset_n, busy, done, error, byte_count
// Optional feature macro: BUS_LOADER_VERIFY_EN (read back and compare every written byte)
module bus_loader
  import bus_loader_pkg::*;
#(
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              RW,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] byte_count
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_len, r_count;
  logic [DATA_W-1:0] r_byte;
  logic w_start, w_hs, w_load, w_expire, w_addr_step;
  assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs = (r_state == S_WAIT_BYTE) && in_valid;
`ifdef BUS_LOADER_VERIFY_EN
  logic r_err;
  // address advances only after the read-back, so VERIFY sees the address just written
  assign w_addr_step = (r_state == S_VERIFY);
  assign error = r_err;
`else
  logic w_last, w_unused;
  assign w_last = (r_count + 16'd1 == r_len);
  assign w_addr_step = (r_state == S_WRITE);
  assign error = 1'b0;
  assign w_unused = ^data_in;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (length == '0) ? S_HOLD : S_WAIT_BYTE;
      S_WAIT_BYTE:    if (in_valid) w_next = S_WRITE;
`ifdef BUS_LOADER_VERIFY_EN
      S_WRITE:        w_next = S_VERIFY;
      S_VERIFY:       w_next = (r_count == r_len) ? S_HOLD : S_WAIT_BYTE;
`else
      S_WRITE:        w_next = w_last ? S_HOLD : S_WAIT_BYTE;
`endif
      S_HOLD:         if (w_expire) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // timer is reloaded on the edge that enters HOLD so HOLD lasts exactly RELEASE_DELAY cycles
  assign w_load = (w_next == S_HOLD) && (r_state != S_HOLD);
  bus_loader_release_timer #(.DELAY(RELEASE_DELAY)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(w_load),
    .expire(w_expire)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_len <= '0;
      r_count <= '0;
      r_byte <= '0;
    end else begin
      if (w_start) begin
        r_addr <= base_addr;
        r_len <= length;
        r_count <= '0;
      end
      if (w_hs) r_byte <= in_data;
      if (r_state == S_WRITE) r_count <= r_count + 16'd1;
      if (w_addr_step) r_addr <= r_addr + 16'd1;
    end
  end
`ifdef BUS_LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) r_err <= 1'b0;
    else if (w_start) r_err <= 1'b0;
    else if (r_state == S_VERIFY && data_in != r_byte) r_err <= 1'b1;
  end
`endif
  assign in_ready = (r_state == S_WAIT_BYTE);
  assign RW = (r_state == S_WRITE) ? RW_WRITE : RW_READ;
  assign data_oe = (r_state == S_WRITE);
  assign addr = r_addr;
  assign data_out = r_byte;
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = (r_state == S_DONE);
  assign cpu_reset_n = (r_state == S_DONE);
  assign byte_count = r_count;
endmodule

// File: doc/bus_loader.md
BUS_LOADER -- requirements
Module: bus_loader

Interface
REQ-001 Parameter: RELEASE_DELAY, default 4, number of clk cycles between load completion and cpu_reset_n release (legal range 1..255).
REQ-002 clk  input  1  single system clock (CPU bus clock domain, e.g. clk_1MHz); all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-005 base_addr  input  16  first bus address written; captured on accepted start.
REQ-006 length  input  16  number of bytes to load; captured on accepted start.
REQ-007 in_data  input  8  byte stream payload.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high.
REQ-010 addr  output  16  bus address to RAM.
REQ-011 data_out  output  8  bus write data; the top level builds the tristate from data_oe.
REQ-012 data_oe  output  1  high when the loader drives the data bus.
REQ-013 data_in  input  8  bus read data, used only when verify is compiled in.
REQ-014 RW  output  1  bus direction, 1 = read, 0 = write; RAM writes on the rising edge at the end of an RW=0 cycle.
REQ-015 cpu_reset_n  output  1  holds the CPU in reset while the loader owns the bus.
REQ-016 busy  output  1  load in progress.
REQ-017 done  output  1  high in DONE state.
REQ-018 error  output  1  sticky verify-mismatch flag.
REQ-019 byte_count  output  16  bytes written in the current load.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_BYTE, WRITE, VERIFY (only with the macro), HOLD, and DONE.
REQ-021 IDLE/DONE + start: capture base_addr and length, clear byte_count and error, drive cpu_reset_n=0, go to WAIT_BYTE, or go to HOLD directly when length==0.
REQ-022 WAIT_BYTE: in_ready=1; on handshake, latch in_data and go to WRITE; in_data SHALL be ignored when in_valid=0.
REQ-023 WRITE lasts exactly one cycle: RW=0, data_oe=1, addr=current address, data_out=latched byte; in_ready=0.
REQ-024 After WRITE: byte_count increments and the address increments by 1 modulo 2^16 (FFFF wraps to 0000).
REQ-025 After WRITE: go to VERIFY if compiled in; otherwise go to WAIT_BYTE, or to HOLD when byte_count reaches length.
REQ-026 Throughput SHALL be one byte per 2 cycles without verify and one byte per 3 cycles with verify, given in_valid held high.
REQ-027 HOLD: count RELEASE_DELAY cycles with cpu_reset_n=0, then go to DONE.
REQ-028 DONE: done=1, cpu_reset_n=1, busy=0.
REQ-029 Outside WRITE: RW=1 and data_oe=0.
REQ-030 busy=1 in WAIT_BYTE, WRITE, VERIFY and HOLD.
REQ-031 start SHALL be ignored while busy.
REQ-032 start in DONE SHALL re-assert cpu_reset_n=0 in the following cycle.
REQ-033 A length of 65536 is not representable; length 0 SHALL mean an empty load.

Reset
REQ-034 reset_n=0 at any clock edge, including mid-load, SHALL force IDLE.
REQ-035 Reset values: addr=0, data_out=0, data_oe=0, RW=1, in_ready=0, busy=0, done=0, error=0, byte_count=0, cpu_reset_n=0.
REQ-036 cpu_reset_n SHALL remain 0 in IDLE after reset until a load completes.

Configuration
REQ-037 Macro BUS_LOADER_VERIFY_EN defined: VERIFY is a one-cycle read (RW=1, data_oe=0, addr = address just written).
REQ-038 With BUS_LOADER_VERIFY_EN, data_in SHALL be compared with the latched byte at the end of VERIFY; a mismatch sets error, which stays set until the next accepted start or reset, and loading continues.
REQ-039 Macro undefined: no VERIFY state, data_in is unused, and error is tied to 0.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, the bus-direction constants (RW_READ=1, RW_WRITE=0), and the address/data width constants (16/8).
REQ-041 One sub-module, bus_loader_release_timer (down-counter for RELEASE_DELAY with load and expire), SHALL be used; all other logic stays flat.

Verification
REQ-042 Basic load: base_addr=0x0200, length=3, bytes A9,01,8D with in_valid held high -> writes 0200=A9, 0201=01, 0202=8D on consecutive WRITE cycles 2 cycles apart; byte_count=3; cpu_reset_n rises exactly RELEASE_DELAY cycles after the last WRITE; done=1.
REQ-043 Wrap and stalls: base_addr=0xFFFE, length=3 with in_valid gaps -> writes FFFE, FFFF, 0000; RW=1 throughout the gaps; no extra writes.
REQ-044 Empty load: length=0 -> no RW=0 cycle; HOLD then DONE; byte_count=0.
REQ-045 Reset mid-load: reset_n=0 after the 2nd byte -> next cycle IDLE, RW=1, data_oe=0, cpu_reset_n=0; a restarted load behaves as in REQ-042.
REQ-046 Verify: with BUS_LOADER_VERIFY_EN, data_in forced to 0x00 when 0x55 is written -> error=1, load completes, error clears on the next start.
REQ-047 Start while busy: start pulsed during WAIT_BYTE with a different base_addr -> ignored; the original address sequence continues.
